// File: rtl/wb_splitter_pkg.sv
// Shared types, defaults and address decode for the Wishbone N-way splitter.
package wb_splitter_pkg;

    localparam logic [31:0] WB_DEFAULT_BASE        = 32'h3000_0000;
    localparam int unsigned WB_DEFAULT_REGION_BITS = 12;

    // Decode is done at a fixed wide width so one function serves any AW up to 64.
    localparam int unsigned DEC_AW    = 64;
    localparam int unsigned DEC_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                 hit;
        logic [DEC_IDX_W-1:0] idx;
    } dec_t;

    // Map an address onto one of n equal regions starting at base.
    function automatic dec_t wb_decode(
        input logic [DEC_AW-1:0] addr,
        input logic [DEC_AW-1:0] base,
        input int unsigned       region_bits,
        input int unsigned       n
    );
        logic [DEC_AW-1:0] off;
        logic [DEC_AW-1:0] idx_full;
        dec_t              d;
        off      = addr - base;
        idx_full = off >> region_bits;
        d.hit    = (addr >= base) && (idx_full < DEC_AW'(n));
        d.idx    = DEC_IDX_W'(idx_full);
        return d;
    endfunction

endpackage

// File: rtl/wb_splitter_timeout.sv
// Per-transfer watchdog: counts enabled cycles from a clear and flags the last allowed one.
module wb_splitter_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            // Watchdog disabled: never expires.
            logic unused_tie;
            assign unused_tie = ^{clk, rst_n, clr, en};
            assign expire_c   = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt_q;

            // Saturating cycle counter, held at zero while cleared.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                end else if (en && (cnt_q != CW'(TIMEOUT))) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign expire_c = en && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_splitter_n.sv
// Wishbone classic single-master to N-slave splitter with registered responses,
// unmapped-address error, timeout watchdog and captured fault address.
module wb_splitter_n
    import wb_splitter_pkg::*;
#(
    parameter int unsigned   NUM_SLAVES  = 4,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter logic [AW-1:0] BASE_ADDR   = AW'(WB_DEFAULT_BASE),
    parameter int unsigned   REGION_BITS = WB_DEFAULT_REGION_BITS,
    parameter int unsigned   TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [AW-1:0]            wbs_adr_i,
    input  logic [DW-1:0]            wbs_dat_i,
    input  logic [DW/8-1:0]          wbs_sel_i,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [DW-1:0]            wbs_dat_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    output logic                     err_pulse_o,
    output logic [AW-1:0]            err_addr_o
);

    localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_e                state_q;
    state_e                state_d;
    dec_t                  dec;
    logic [IW-1:0]         idx_q;
    logic                  sel_ack;
    logic                  sel_err;
    logic [DW-1:0]         sel_dat;
    logic                  tmo_expire_c;
    logic                  take_req;
    logic                  finish;
    logic                  finish_err;
    logic [NUM_SLAVES-1:0] strobe_d;

    // Region decode of the live master address.
    always_comb begin
        dec = wb_decode(DEC_AW'(wbs_adr_i), DEC_AW'(BASE_ADDR), REGION_BITS, NUM_SLAVES);
    end

    // Response and data from the currently selected slave only.
    assign sel_ack = s_ack_i[idx_q];
    assign sel_err = s_err_i[idx_q];
    assign sel_dat = s_dat_i[int'(idx_q) * DW +: DW];

    // Watchdog runs only while a slave is strobed.
    wb_splitter_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clr      (state_q != ACTIVE),
        .en       (state_q == ACTIVE),
        .expire_c (tmo_expire_c)
    );

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, strobe vector and response qualifiers.
    always_comb begin
        state_d    = state_q;
        take_req   = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        strobe_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    take_req = 1'b1;
                    if (dec.hit) begin
                        state_d  = ACTIVE;
                        strobe_d = NUM_SLAVES'(1) << dec.idx;
                    end else begin
                        state_d    = RESP;
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // A slave response beats a simultaneous timeout; error beats ack.
                if (sel_ack || sel_err) begin
                    state_d    = RESP;
                    finish     = 1'b1;
                    finish_err = sel_err;
                end else if (tmo_expire_c) begin
                    state_d    = RESP;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    strobe_d = NUM_SLAVES'(1) << idx_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered broadcast, strobes, master response and fault capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            s_sel_o     <= '0;
            s_we_o      <= 1'b0;
            s_cyc_o     <= '0;
            s_stb_o     <= '0;
            idx_q       <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            wbs_dat_o   <= '0;
            err_pulse_o <= 1'b0;
            err_addr_o  <= '0;
        end else begin
            s_cyc_o     <= strobe_d;
            s_stb_o     <= strobe_d;
            wbs_ack_o   <= finish && !finish_err;
            wbs_err_o   <= finish && finish_err;
            err_pulse_o <= finish && finish_err;
            if (take_req) begin
                s_adr_o <= wbs_adr_i;
                s_dat_o <= wbs_dat_i;
                s_sel_o <= wbs_sel_i;
                s_we_o  <= wbs_we_i;
                idx_q   <= IW'(dec.idx);
            end
            if (finish) begin
                wbs_dat_o <= finish_err ? '0 : sel_dat;
            end
            // A miss errors in the same edge that captures the address.
            if (finish && finish_err) begin
                err_addr_o <= (state_q == IDLE) ? wbs_adr_i : s_adr_o;
            end
        end
    end

endmodule

// File: doc/wb_splitter_n.md
# wb_splitter_n

Parametrised Wishbone classic single-master to N-slave splitter with registered responses, replacing the fixed four-way splitter in the user project wrapper. It decodes equal-sized, contiguous address regions from a base address and routes each transfer to one slave. It adds three things the fixed splitter lacks: an error response for unmapped addresses, a per-transfer timeout watchdog, and a captured fault address with an error pulse that can drive a user IRQ.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports, legal range 1..16
- AW, 32, address width
- DW, 32, data width, multiple of 8
- BASE_ADDR, 32'h3000_0000, start of slave 0 region, aligned to 2^REGION_BITS
- REGION_BITS, 12, log2 of region size (4 KB default)
- TIMEOUT, 255, maximum cycles to wait for a slave response; 0 disables the watchdog

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master control
- wbs_adr_i  in  AW  master address
- wbs_dat_i  in  DW  master write data
- wbs_sel_i  in  DW/8  byte selects
- wbs_ack_o, wbs_err_o  out  1 each  master response
- wbs_dat_o  out  DW  master read data
- s_adr_o  out  AW  broadcast address, registered
- s_dat_o  out  DW  broadcast write data, registered
- s_sel_o  out  DW/8  broadcast byte selects, registered
- s_we_o  out  1  broadcast write enable, registered
- s_cyc_o, s_stb_o  out  NUM_SLAVES  one-hot per-slave strobes
- s_dat_i  in  NUM_SLAVES*DW  slave read data; slave k uses bits [k*DW +: DW]
- s_ack_i, s_err_i  in  NUM_SLAVES  slave responses
- err_pulse_o  out  1  one-cycle pulse on every wbs_err_o
- err_addr_o  out  AW  address of the most recent errored transfer

## Operation
- Decode: off = wbs_adr_i - BASE_ADDR; idx = off >> REGION_BITS.
  - The transfer is a hit when wbs_adr_i >= BASE_ADDR and idx < NUM_SLAVES.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, on wbs_cyc_i & wbs_stb_i:
  - Register the address, write data, select and we onto the broadcast s_* outputs, and register idx.
  - Hit: go to ACTIVE.
  - Miss: set the error flag and go to RESP.
- ACTIVE:
  - s_cyc_o[idx] and s_stb_o[idx] are high; all other bits are 0.
  - The timeout counter starts at 0 and increments each cycle.
  - If s_ack_i[idx] | s_err_i[idx]: latch s_dat_i slice idx and the error flag (s_err_i[idx]), then go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: set the error flag and go to RESP.
  - Else if wbs_cyc_i == 0 (master abort): go to IDLE with no response.
- RESP:
  - Assert wbs_ack_o (flag clear) or wbs_err_o (flag set) for exactly one cycle.
  - wbs_dat_o holds the latched data; it is 0 on error.
  - Then go to IDLE.
- Every error (miss, slave error, timeout) pulses err_pulse_o in the RESP cycle and loads err_addr_o with the registered address.
- Simultaneous events:
  - s_ack_i and s_err_i together: error wins.
  - A response arriving in the same cycle the timeout fires: the response wins.
  - Responses from non-selected slaves are ignored.
- Reset (asynchronous, any state): FSM returns to IDLE.
  - All outputs go to 0: s_cyc_o, s_stb_o, wbs_ack_o, wbs_err_o, wbs_dat_o, err_pulse_o, err_addr_o, and all s_* broadcast outputs.
  - An in-flight transfer is dropped.
- Timeout counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Request sampled at edge 0 → slave strobe visible in cycle 1.
- A slave that responds combinationally in cycle 1 → wbs_ack_o high in cycle 2. Minimum latency is 2 cycles.
- Slave response in cycle k → master response in cycle k+1.
- Unmapped address sampled at edge 0 → wbs_err_o high in cycle 1.
- Timeout → wbs_err_o high in cycle TIMEOUT+1 after the request is sampled.
- Back-to-back transfers: the FSM is back in IDLE the cycle after the response, so a new request can be sampled at that edge. Peak throughput is one transfer per 3 cycles.
- The master must deassert wbs_stb_i after the response, per Wishbone classic rules.

## Structure
- Shared package wb_splitter_pkg holds:
  - the state enum (IDLE/ACTIVE/RESP)
  - a decode function (addr, base, region_bits, n → hit, idx)
  - the default BASE_ADDR and REGION_BITS constants reused by the wrapper
- One natural sub-module, wb_splitter_timeout: a counter with clear, enable and expire outputs, parametrised by TIMEOUT and tied off when TIMEOUT == 0.
- The wrapper instantiates one wb_splitter_n with NUM_SLAVES=4 in place of the fixed splitter.

## Test plan
- Read, slave 2 at 0x3000_2004, slave acks with 0xDEADBEEF one cycle after its strobe → s_stb_o == 4'b0100, wbs_ack_o in cycle 3, wbs_dat_o == 0xDEADBEEF, no other strobe seen.
- Write to 0x3000_4000 (unmapped, NUM_SLAVES=4) → no slave strobe, wbs_err_o in cycle 1, err_pulse_o high, err_addr_o == 0x3000_4000.
- Write to slave 1 with TIMEOUT=8 and no slave response → wbs_err_o exactly 9 cycles after sampling, s_cyc_o returns to 0, err_addr_o == 0x3000_1000.
- Slave 0 asserts ack and err in the same cycle → wbs_err_o only, wbs_dat_o == 0. Repeat with ack landing exactly on timeout expiry → wbs_ack_o.
- Master drops wbs_cyc_i in ACTIVE → slave strobes clear next cycle, no wbs_ack_o/wbs_err_o; the following transfer to slave 3 completes normally.
- wb_rst_ni pulled low mid-ACTIVE → all outputs 0 immediately; after release, a read of slave 0 succeeds with 2-cycle latency.
